add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter NIB, default 4: number of 4-bit slices per operand; operand width W = 4*NIB.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand request present.
REQ-005 in_ready  output  1  controller can accept a request.
REQ-006 a  input  W  operand A, sampled on accept.
REQ-007 b  input  W  operand B, sampled on accept.
REQ-008 cin  input  1  carry-in, sampled on accept; ignored when sub=1.
REQ-009 sub  input  1  0 = A+B+cin, 1 = A-B, sampled on accept.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 sum  output  W  result.
REQ-013 cout  output  1  carry out of MSB slice; for sub, 1 = no borrow.
REQ-014 ovf  output  1  signed two's-complement overflow.
REQ-015 zero  output  1  sum == 0.

Function
REQ-016 States IDLE, RUN, DONE; the FSM SHALL hold exactly one.
REQ-017 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge = accept -> latch a, b, sub; B' = sub ? ~b : b; carry register = sub ? 1 : cin; slice index = 0; go to RUN.
REQ-018 RUN: each cycle one 4-bit slice k (index value) of A and B' plus carry register goes through the sub-module; slice result is written to sum[4k+3:4k]; carry register <= slice carry-out; index increments.
REQ-019 RUN with index = NIB-1: after the write, go to DONE; cout <= final carry; ovf <= carry into MSB XOR carry out of MSB.
REQ-020 Latency: accept at edge E0; out_valid SHALL be 1 after edge E(NIB) (E4 by default), never earlier.
REQ-021 DONE: out_valid=1; sum, cout, ovf, zero SHALL be stable until handshake.
REQ-022 out_valid & out_ready at an edge -> IDLE; in_ready SHALL be 1 in the next cycle; no request is accepted in that same edge (no overlap).
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid in those states is ignored, and a, b, cin, sub changes SHALL NOT affect the result in progress.
REQ-024 out_ready held low in DONE -> remain in DONE indefinitely with outputs held.
REQ-025 zero SHALL be combinational from the sum register, valid whenever out_valid=1.
REQ-026 Carry wrap: an all-ones slice with carry-in 1 SHALL propagate carry into the next slice; no carry is lost between cycles.
REQ-027 Slice index width = clog2(NIB), min 1; NIB=1 SHALL complete in one RUN cycle.

Reset
REQ-028 rst_n=0 at an edge, in any state including mid-RUN -> IDLE; in-flight operation discarded.
REQ-029 Reset values: in_ready=1 in the cycle after reset release, out_valid=0, sum=0, cout=0, ovf=0, zero=1, index=0, carry register=0.

Structure
REQ-030 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the slice width constant 4.
REQ-031 One sub-module, adder4_cla: 4-bit carry-lookahead slice (a, b, cin -> sum, cout, plus carry into bit 3 for overflow); instantiated once, time-shared across slices.
REQ-032 No other sub-modules; FSM, index counter, operand and result registers live in add_seq_ctrl.

Verification
REQ-033 a=0x00FF, b=0x0001, cin=0, sub=0 -> sum=0x0100, cout=0, ovf=0, zero=0, out_valid 4 cycles after accept.
REQ-034 a=0xFFFF, b=0xFFFF, cin=1, sub=0 -> sum=0xFFFF, cout=1, ovf=0.
REQ-035 a=0x0003, b=0x0005, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0; then a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1.
REQ-036 a=0x1234, b=0xEDCC, sub=0, cin=0 -> sum=0x0000, cout=1, zero=1; out_ready low 10 cycles -> outputs held, in_ready=0, in_valid pulses ignored.
REQ-037 rst_n low for one edge after 2 RUN cycles -> IDLE, out_valid=0, in_ready=1; next request a=0x0001, b=0x0001 -> sum=0x0002 with normal latency.
REQ-038 Back-to-back: in_valid held high with two requests -> second accepted only in the cycle after the first result handshake.

Source files
------------

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the slice-serial adder controller: FSM states,
// slice width and the index-width helper.
package add_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice index needs at least one bit even when there is a single slice.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_adder4_cla.sv
// 4-bit carry-lookahead slice; also exposes the carry into bit 3 so the
// caller can derive signed overflow on the most significant slice.
module adder4_cla
    import add_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout,
    output logic               o_c3
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is a flat sum of generate/propagate terms, no ripple.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[SLICE_W-1:0];
    assign o_cout = w_c[4];
    assign o_c3   = w_c[3];

endmodule

// File: rtl/add_seq_ctrl.sv
// Slice-serial add/subtract controller: one 4-bit lookahead slice is reused
// over NIB cycles, with the carry held in a register between slices.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int NIB = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLICE_W*NIB-1:0] a,
    input  logic [SLICE_W*NIB-1:0] b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE_W*NIB-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   zero,
    output logic [1:0]             state_dbg
);

    localparam int W     = SLICE_W * NIB;
    localparam int IDX_W = idx_width(NIB);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; ready depends only on state, never on the partner's valid.
    state_t             r_state;
    state_t             r_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;

    logic [IDX_W+1:0]   w_lo;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic               w_slice_c3;
    logic               w_last;
    logic               w_accept;

    assign w_lo     = {r_idx, 2'b00};
    assign w_last   = (r_idx == IDX_W'(NIB - 1));
    assign w_accept = (r_state == ST_IDLE) && in_valid;

    adder4_cla u_slice (
        .i_a    (r_a[w_lo +: SLICE_W]),
        .i_b    (r_b[w_lo +: SLICE_W]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout),
        .o_c3   (w_slice_c3)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  r_next = ST_RUN;
            ST_RUN:  if (w_last)    r_next = ST_DONE;
            ST_DONE: if (out_ready) r_next = ST_IDLE;
            default:                r_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        state_dbg = r_state;
    end

    // Subtraction is A + ~B + 1, so the inverted operand is stored up front.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum[w_lo +: SLICE_W] <= w_slice_sum;
            r_carry                <= w_slice_cout;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_slice_cout;
                r_ovf  <= w_slice_c3 ^ w_slice_cout;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = (r_sum == '0);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: hand-computed vectors checked with
// immediate assertions, including latency, hold, reset and back-to-back cases.
module tb_add_seq_ctrl;
    import add_seq_ctrl_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    add_seq_ctrl #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while IDLE; the next rising edge accepts.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        exp_q.push_back({ec, eo, es});
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic hold_valid);
        int lat;
        logic [W+1:0] e;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) begin
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        end
        check({tag, "_in_ready_run"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_state_run"}, {30'b0, state_dbg}, 32'(ST_RUN));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        e = exp_q.pop_front();
        check({tag, "_sum"},  {16'b0, sum},     {16'b0, e[W-1:0]});
        check({tag, "_cout"}, {31'b0, cout},    {31'b0, e[W+1]});
        check({tag, "_ovf"},  {31'b0, ovf},     {31'b0, e[W]});
        check({tag, "_zero"}, {31'b0, zero},    {31'b0, (e[W-1:0] == '0)});
        check({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_hs_in_ready"},  {31'b0, in_ready},  32'd1);
        check({tag, "_hs_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_hs_state"},     {30'b0, state_dbg}, 32'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sum",       {16'b0, sum},       32'h0);
        check("rst_cout",      {31'b0, cout},      32'd0);
        check("rst_ovf",       {31'b0, ovf},       32'd0);
        check("rst_zero",      {31'b0, zero},      32'd1);
        check("rst_state",     {30'b0, state_dbg}, 32'(ST_IDLE));

        // Carry across slice boundary.
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("add_00ff", 1'b0);
        handshake("add_00ff");

        // All-ones slices with carry-in: carry propagates through every slice.
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("add_ffff", 1'b0);
        handshake("add_ffff");

        // Subtract with borrow; cin is ignored.
        start_op(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_3_5", 1'b0);
        handshake("sub_3_5");

        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_ovf", 1'b0);
        handshake("add_ovf");

        // Zero result, consumer stalls for 10 cycles with stray requests.
        start_op(16'h1234, 16'hEDCC, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_zero", 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("hold_sum",       {16'b0, sum},       32'h0);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready",  {31'b0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        check("hold_cout", {31'b0, cout}, 32'd1);
        check("hold_zero", {31'b0, zero}, 32'd1);
        handshake("add_zero");

        // Reset mid-RUN discards the operation.
        start_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_state",     {30'b0, state_dbg}, 32'(ST_IDLE));
        check("midrst_zero",      {31'b0, zero},      32'd1);
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_op("after_rst", 1'b0);
        handshake("after_rst");

        // Back-to-back: in_valid stays high; second request waits for handshake.
        start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("b2b_first", 1'b1);
        a = 16'h8000; b = 16'h0001; cin = 1'b0; sub = 1'b1;
        repeat (2) @(negedge clk);
        check("b2b_wait_state", {30'b0, state_dbg}, 32'(ST_DONE));
        check("b2b_wait_sum",   {16'b0, sum},       32'h1000);
        handshake("b2b_first");
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("b2b_second", 1'b0);
        handshake("b2b_second");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
